// File: rtl/ram4_16.sv
// Four-word x 16-bit register bank with a combinational read port and a
// handshaked sequential scan port that streams mem[0..3] to a downstream consumer.
module ram4_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic [1:0]  address,
    input  logic        load,
    output logic [15:0] out,
    input  logic        scan_start,
    input  logic        scan_ready,
    output logic        scan_valid,
    output logic [1:0]  scan_addr,
    output logic [15:0] scan_out,
    output logic        scan_busy,
    output logic        scan_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_mem [4];
    logic [1:0]  r_scan_addr;
    logic [1:0]  w_scan_addr_nxt;
    logic [15:0] r_scan_out;
    logic        w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 16'h0000;
            end
        end else if (load) begin
            r_mem[address] <= in;
        end
    end

    assign out = r_mem[address];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_capture       = 1'b0;
        w_scan_addr_nxt = r_scan_addr;
        case (r_state)
            S_IDLE: begin
                if (scan_start) begin
                    w_state_nxt     = S_SCAN;
                    w_capture       = 1'b1;
                    w_scan_addr_nxt = 2'd0;
                end
            end
            S_SCAN: begin
                if (scan_ready) begin
                    if (r_scan_addr == 2'd3) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_capture       = 1'b1;
                        w_scan_addr_nxt = r_scan_addr + 2'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture reads r_mem before any same-edge write lands, so old data is streamed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_addr <= 2'd0;
            r_scan_out  <= 16'h0000;
        end else if (w_capture) begin
            r_scan_addr <= w_scan_addr_nxt;
            r_scan_out  <= r_mem[w_scan_addr_nxt];
        end
    end

    assign scan_valid = (r_state == S_SCAN);
    assign scan_done  = (r_state == S_DONE);
    assign scan_busy  = (r_state != S_IDLE);
    assign scan_addr  = r_scan_addr;
    assign scan_out   = r_scan_out;

endmodule

// File: tb/tb_ram4_16.sv
// Self-checking bench for ram4_16: write/read, scan streaming with stalls,
// write collision during capture, ignored restart, async reset mid-scan.
module tb_ram4_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [1:0]  address;
    logic        load;
    logic [15:0] out;
    logic        scan_start;
    logic        scan_ready;
    logic        scan_valid;
    logic [1:0]  scan_addr;
    logic [15:0] scan_out;
    logic        scan_busy;
    logic        scan_done;

    ram4_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .address    (address),
        .load       (load),
        .out        (out),
        .scan_start (scan_start),
        .scan_ready (scan_ready),
        .scan_valid (scan_valid),
        .scan_addr  (scan_addr),
        .scan_out   (scan_out),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    typedef struct packed {
        logic [1:0]  addr;
        logic [15:0] data;
    } scan_exp_t;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [15:0] model [4];
    scan_exp_t   exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (rst_n && scan_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the FSM idle; leaves it idle at a negedge.
    task automatic do_scan(input int stall_at, input int stall_n, input int wr_at, input bit poke_start);
        int        cyc;
        int        stalls;
        bit        last_acc;
        scan_exp_t e;
        done_cnt = 0;
        for (int a = 0; a < 4; a++) begin
            e.addr = 2'(a);
            e.data = model[a];
            exp_q.push_back(e);
        end
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        stalls   = stall_n;
        cyc      = 0;
        last_acc = 1'b0;
        while (!last_acc && cyc < 40) begin
            scan_ready = 1'b1;
            load       = 1'b0;
            if (scan_valid && int'(scan_addr) == stall_at && stalls > 0) begin
                scan_ready = 1'b0;
                stalls--;
            end
            if (wr_at > 0 && scan_valid && scan_ready && int'(scan_addr) == wr_at - 1) begin
                load    = 1'b1;
                address = 2'(wr_at);
                in      = 16'h1234;
            end
            if (poke_start && cyc == 1) scan_start = 1'b1;
            @(negedge clk);
            if (scan_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scan_extra_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("scan_addr", 32'(scan_addr), 32'(e.addr));
                    chk("scan_out", 32'(scan_out), 32'(e.data));
                    if (scan_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) last_acc = 1'b1;
                    end
                end
            end
            @(posedge clk); #1;
            if (load) model[address] = in;
            scan_start = 1'b0;
            load       = 1'b0;
            cyc++;
        end
        chk("scan_completed", 32'(last_acc), 32'd1);
        scan_ready = 1'b0;
        chk("done_after_last", 32'(scan_done), 32'd1);
        chk("valid_after_last", 32'(scan_valid), 32'd0);
        chk("busy_in_done", 32'(scan_busy), 32'd1);
        chk("addr_hold_3", 32'(scan_addr), 32'd3);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(scan_done), 32'd0);
        chk("busy_low_2cyc", 32'(scan_busy), 32'd0);
        chk("addr_idle_3", 32'(scan_addr), 32'd3);
        @(negedge clk);
        chk("done_pulse_count", 32'(done_cnt), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        in         = 16'h0000;
        address    = 2'd0;
        load       = 1'b0;
        scan_start = 1'b0;
        scan_ready = 1'b0;
        for (int a = 0; a < 4; a++) model[a] = 16'h0000;
        #22;
        chk("rst_valid", 32'(scan_valid), 32'd0);
        chk("rst_busy", 32'(scan_busy), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        chk("rst_scan_addr", 32'(scan_addr), 32'd0);
        chk("rst_scan_out", 32'(scan_out), 32'd0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1 chk("rst_out", 32'(out), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Writes: value visible only after the edge.
        for (int a = 0; a < 4; a++) begin
            logic [15:0] pat [4];
            pat[0] = 16'h5555; pat[1] = 16'hAAAA; pat[2] = 16'h00FF; pat[3] = 16'hFF00;
            @(posedge clk); #1;
            address = 2'(a);
            in      = pat[a];
            load    = 1'b1;
            #1 chk("wr_pre_edge", 32'(out), 32'(model[a]));
            @(posedge clk); #1;
            model[a] = pat[a];
            load     = 1'b0;
            chk("wr_post_edge", 32'(out), 32'(model[a]));
        end
        for (int a = 3; a >= 0; a--) begin
            address = 2'(a);
            #1 chk("read_back", 32'(out), 32'(model[a]));
        end

        // Ready while idle must not start anything.
        @(negedge clk);
        scan_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_idle_busy", 32'(scan_busy), 32'd0);
        scan_ready = 1'b0;
        @(negedge clk);

        do_scan(-1, 0, -1, 1'b0);
        do_scan(1, 3, -1, 1'b0);
        do_scan(-1, 0, 2, 1'b0);
        address = 2'd2;
        #1 chk("collide_out_new", 32'(out), 32'h1234);
        do_scan(-1, 0, -1, 1'b1);

        // Back-to-back scans with fresh random data.
        for (int a = 0; a < 4; a++) begin
            @(posedge clk); #1;
            address = 2'(a);
            in      = 16'($urandom);
            load    = 1'b1;
            @(posedge clk); #1;
            model[a] = in;
            load     = 1'b0;
        end
        @(negedge clk);
        do_scan(2, 1, -1, 1'b0);
        do_scan(-1, 0, -1, 1'b0);

        // Async reset between edges mid-scan.
        done_cnt   = 0;
        scan_start = 1'b1;
        scan_ready = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(scan_valid), 32'd0);
        chk("midrst_busy", 32'(scan_busy), 32'd0);
        chk("midrst_done", 32'(scan_done), 32'd0);
        chk("midrst_addr", 32'(scan_addr), 32'd0);
        chk("midrst_scan_out", 32'(scan_out), 32'd0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1 chk("midrst_out", 32'(out), 32'd0);
            model[a] = 16'h0000;
        end
        scan_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("post_rst_busy", 32'(scan_busy), 32'd0);
        do_scan(-1, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
